// File: rtl/npu_result_reader.sv
// npu_result_reader: streams the four byte-wide result RAM banks back to the
// host as packed 32-bit words {q0,q1,q2,q3}, through a 2-entry prefetch buffer
// so the host can pop one word per cycle.
module npu_result_reader #(
   parameter int ADDR_W    = 11,
   parameter int NUM_WORDS = 1857,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,        // asynchronous, active-low
   input  logic [31:0]       control_reg,
   output logic [ADDR_W-1:0] res_addr,
   output logic              res_rd_en,
   input  logic [7:0]        res_q0,
   input  logic [7:0]        res_q1,
   input  logic [7:0]        res_q2,
   input  logic [7:0]        res_q3,
   output logic [31:0]       readdata,
   output logic              rd_valid,
   input  logic              read,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(NUM_WORDS);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   // State flops and their next-state values
   logic [1:0]        state_q, state_d;
   logic              start_q, start_d;
   logic              start_prev_q, start_prev_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        occ_q, occ_d;
   logic [31:0]       head_q, head_d;
   logic [31:0]       tail_q, tail_d;
   logic              rd_valid_q, rd_valid_d;

   // Combinational helpers
   logic        start_evt;
   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  slots;
   logic [31:0] ret_word;

   // Start event, pop/push strobes and the read-issue decision
   always_comb begin
      // NOTE: every signal assigned in an always_comb gets a value on every
      // path (here directly, elsewhere via a default first) so no latch forms.
      start_d      = (control_reg == 32'h3);
      start_prev_d = start_q;
      start_evt    = start_q & ~start_prev_q;
      pop          = read & rd_valid_q;
      push         = inflight_q;
      ret_word     = {res_q0, res_q1, res_q2, res_q3};
      // Words already owned by the buffer once this cycle's pop is taken out;
      // pop implies occupancy > 0, so this never underflows.
      slots        = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue        = (state_q == ST_RUN) && (issue_cnt_q != LAST_CNT) && (slots < 3'd2);
      inflight_d   = issue;
   end

   // Run-control FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_evt) state_d = ST_RUN;
         ST_RUN:   if (issue_cnt_q == LAST_CNT) state_d = ST_DRAIN;
         ST_DRAIN: if ((occ_q == 2'd0) && !inflight_q) state_d = ST_DONE;
         ST_DONE:  if (!start_q) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Issue counter, read address and host word counter
   always_comb begin
      issue_cnt_d  = issue_cnt_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      if (state_q == ST_IDLE) begin
         issue_cnt_d  = '0;
         addr_d       = BASE;
         word_count_d = '0;
      end else begin
         // issue is already gated by the count limit, so this saturates
         if (issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            addr_d      = addr_q + 1'b1;
         end
         if (pop && (word_count_q != LAST_CNT)) begin
            word_count_d = word_count_q + 1'b1;
         end
      end
   end

   // 2-entry prefetch buffer: head is the registered readdata, tail the spare
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({push, pop})
         2'b11: begin
            if (occ_q == 2'd2) begin
               head_d = tail_q;
               tail_d = ret_word;
            end else begin
               head_d = ret_word;
            end
         end
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d = ret_word;
               occ_d  = 2'd1;
            end else begin
               tail_d = ret_word;
               occ_d  = 2'd2;
            end
         end
         2'b01: begin
            if (occ_q == 2'd2) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end else begin
               occ_d  = 2'd0;
            end
         end
         default: ;
      endcase
      rd_valid_d = (occ_d != 2'd0);
   end

   // All state registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the buffer data registers are reset too, because readdata is
         // a direct register output and must read 0 while in reset.
         state_q      <= ST_IDLE;
         start_q      <= 1'b0;
         start_prev_q <= 1'b0;
         addr_q       <= BASE;
         issue_cnt_q  <= '0;
         word_count_q <= '0;
         inflight_q   <= 1'b0;
         occ_q        <= 2'd0;
         head_q       <= '0;
         tail_q       <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         start_q      <= start_d;
         start_prev_q <= start_prev_d;
         addr_q       <= addr_d;
         issue_cnt_q  <= issue_cnt_d;
         word_count_q <= word_count_d;
         inflight_q   <= inflight_d;
         occ_q        <= occ_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   assign res_addr   = addr_q;
   assign res_rd_en  = issue;
   assign readdata   = head_q;
   assign rd_valid   = rd_valid_q;
   assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done       = (state_q == ST_DONE);
   assign word_count = word_count_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// Self-checking bench for npu_result_reader: reset values, start timing,
// host stalls, random backpressure, restart rules and reset mid-stream.
module tb_npu_result_reader;

   localparam int ADDR_W = 11;
   localparam int NUM    = 1857;
   localparam int BASE   = 0;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       control_reg;
   logic [ADDR_W-1:0] res_addr;
   logic              res_rd_en;
   logic [7:0]        res_q0 = 8'h00, res_q1 = 8'h00, res_q2 = 8'h00, res_q3 = 8'h00;
   logic [31:0]       readdata;
   logic              rd_valid;
   logic              read;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   word_count;

   int checks   = 0;
   int failures = 0;
   logic [31:0] captured [NUM];

   npu_result_reader #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .control_reg(control_reg),
      .res_addr(res_addr), .res_rd_en(res_rd_en),
      .res_q0(res_q0), .res_q1(res_q1), .res_q2(res_q2), .res_q3(res_q3),
      .readdata(readdata), .rd_valid(rd_valid), .read(read),
      .busy(busy), .done(done), .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Result RAM banks: mem[a] = {a, a+1, a+2, a+3} (bytes), 1-cycle read latency
   always @(posedge clk) begin
      if (res_rd_en) begin
         res_q0 <= res_addr[7:0];
         res_q1 <= res_addr[7:0] + 8'd1;
         res_q2 <= res_addr[7:0] + 8'd2;
         res_q3 <= res_addr[7:0] + 8'd3;
      end
   end

   function automatic logic [31:0] exp_word(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {b, b + 8'd1, b + 8'd2, b + 8'd3};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pops words under a given read pattern until done; gathers error counts.
   task automatic run_stream(input int duty, input int stall_at, input int stall_len,
                             input int drop_at, output int n_words, output int data_errs,
                             output int stab_errs, output int wc_errs, output int max_ahead,
                             output int done_lat, output bit timed_out);
      int last_pop_cyc = 0;
      int stall_left   = 0;
      int ahead;
      bit stall_used   = 0;
      bit prev_hold    = 0;
      logic [31:0] prev_data = '0;
      n_words = 0; data_errs = 0; stab_errs = 0; wc_errs = 0; max_ahead = 0;
      done_lat = -1; timed_out = 1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         if (done) begin
            done_lat  = cyc - last_pop_cyc;
            timed_out = 0;
            break;
         end
         if (prev_hold && rd_valid && (readdata !== prev_data)) stab_errs++;
         if (int'(word_count) != n_words) wc_errs++;
         ahead = int'(res_addr) - BASE - n_words;
         if (ahead > max_ahead) max_ahead = ahead;
         if (drop_at >= 0 && n_words >= drop_at) control_reg = 32'h0;
         if (!stall_used && stall_at >= 0 && n_words == stall_at) begin
            stall_used = 1;
            stall_left = stall_len;
         end
         if (stall_left > 0) begin
            read = 1'b0;
            stall_left--;
         end else begin
            read = ($urandom_range(99, 0) < duty);
         end
         if (read && rd_valid) begin
            if (n_words >= NUM) data_errs++;
            else begin
               if (readdata !== exp_word(n_words)) data_errs++;
               captured[n_words] = readdata;
            end
            n_words++;
            last_pop_cyc = cyc;
            prev_hold = 0;
         end else begin
            prev_hold = rd_valid;
            prev_data = readdata;
         end
      end
      read = 1'b0;
   endtask

   // Drop control_reg, wait for IDLE and confirm counters are cleared.
   task automatic go_idle(input string tag);
      bit ok = 0;
      control_reg = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!done && !busy) begin
            ok = 1;
            break;
         end
      end
      @(negedge clk);
      check({tag, "_idle_reached"}, {31'd0, ok}, 32'd1);
      check({tag, "_idle_wc"}, 32'(word_count), 32'd0);
      check({tag, "_idle_addr"}, 32'(res_addr), 32'(BASE));
   endtask

   typedef struct {
      string      name;
      int         duty;
      int         stall_at;
      int         stall_len;
      int         drop_at;
      int         exp_words;
      logic       exp_done_held;
   } scen_t;

   typedef struct {
      int          idx;
      logic [31:0] exp;
   } spot_t;

   initial begin
      scen_t scen [5];
      spot_t spots [6];
      int n, de, se, we, ma, dl;
      bit to;
      int hold_err, rden_err;
      logic [31:0] held;

      scen[0] = '{"stall20",   100, 100, 20, -1, NUM, 1'b1};
      scen[1] = '{"rand30",     30,  -1,  0, -1, NUM, 1'b1};
      scen[2] = '{"drop_ctrl",  30,  -1,  0, 50, NUM, 1'b0};
      scen[3] = '{"rand60_st",  60, 700, 25, -1, NUM, 1'b1};
      scen[4] = '{"full_again",100,  -1,  0, -1, NUM, 1'b1};

      spots[0] = '{0,    32'h00010203};
      spots[1] = '{1,    32'h01020304};
      spots[2] = '{255,  32'hFF000102};
      spots[3] = '{300,  32'h2C2D2E2F};
      spots[4] = '{511,  32'hFF000102};
      spots[5] = '{1856, 32'h40414243};

      // Reset held low for 3 cycles with control_reg = 3
      reset = 1'b0; control_reg = 32'h3; read = 1'b0;
      rden_err = 0;
      repeat (3) begin
         @(negedge clk);
         if (res_rd_en) rden_err++;
      end
      check("rst_rd_en_never", rden_err, 0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      check("rst_res_addr", 32'(res_addr), 32'(BASE));
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      control_reg = 32'h0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Start timing: control written, start_q rises at edge N
      control_reg = 32'h3;
      @(negedge clk);  // after N
      check("t_n_busy", {31'd0, busy}, 32'd0);
      check("t_n_rd_en", {31'd0, res_rd_en}, 32'd0);
      @(negedge clk);  // after N+1
      check("t_n1_busy", {31'd0, busy}, 32'd1);
      check("t_n1_rd_en", {31'd0, res_rd_en}, 32'd1);
      check("t_n1_addr", 32'(res_addr), 32'(BASE));
      @(negedge clk);  // after N+2
      check("t_n2_rd_valid", {31'd0, rd_valid}, 32'd0);
      @(negedge clk);  // after N+3
      check("t_n3_rd_valid", {31'd0, rd_valid}, 32'd1);
      check("t_n3_word0", readdata, 32'h00010203);
      check("t_n3_rd_en", {31'd0, res_rd_en}, 32'd0);
      @(negedge clk);  // after N+4: buffer full
      check("t_n4_addr", 32'(res_addr), 32'(BASE + 2));

      // Host stall: 20 cycles with read low, nothing more issued, head stable
      held = readdata; hold_err = 0; rden_err = 0;
      repeat (20) begin
         @(negedge clk);
         if (readdata !== held) hold_err++;
         if (res_rd_en) rden_err++;
      end
      check("stall_hold_readdata", hold_err, 0);
      check("stall_no_issue", rden_err, 0);
      check("stall_addr", 32'(res_addr), 32'(BASE + 2));

      // Drain the rest of the first run with read held high
      run_stream(100, -1, 0, -1, n, de, se, we, ma, dl, to);
      check("full_timeout", {31'd0, to}, 32'd0);
      check("full_words", n, NUM);
      check("full_data_errs", de, 0);
      check("full_wc_errs", we, 0);
      check("full_ahead_le2", {31'd0, ma <= 2}, 32'd1);
      check("full_done_lat", dl, 2);
      check("full_word_count", 32'(word_count), 32'(NUM));
      for (int s = 0; s < 6; s++) begin
         check($sformatf("spot_w%0d", spots[s].idx), captured[spots[s].idx], spots[s].exp);
      end

      // DONE with control_reg still 3: rewriting 3 must not restart
      control_reg = 32'h3;
      hold_err = 0;
      repeat (5) begin
         @(negedge clk);
         if (!done || busy || res_rd_en) hold_err++;
      end
      check("done_no_restart", hold_err, 0);
      go_idle("after_full");

      // Table-driven runs
      for (int k = 0; k < 5; k++) begin
         control_reg = 32'h3;
         run_stream(scen[k].duty, scen[k].stall_at, scen[k].stall_len, scen[k].drop_at,
                    n, de, se, we, ma, dl, to);
         check({scen[k].name, "_timeout"}, {31'd0, to}, 32'd0);
         check({scen[k].name, "_words"}, n, scen[k].exp_words);
         check({scen[k].name, "_data_errs"}, de, 0);
         check({scen[k].name, "_stab_errs"}, se, 0);
         check({scen[k].name, "_wc_errs"}, we, 0);
         check({scen[k].name, "_ahead_le2"}, {31'd0, ma <= 2}, 32'd1);
         check({scen[k].name, "_done_lat"}, dl, 2);
         @(negedge clk);
         check({scen[k].name, "_done_next"}, {31'd0, done}, {31'd0, scen[k].exp_done_held});
         go_idle(scen[k].name);
      end

      // Reset mid-stream at word 500, then restart from BASE_ADDR
      control_reg = 32'h3;
      read = 1'b1;
      to = 1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (int'(word_count) >= 500) begin
            to = 0;
            break;
         end
      end
      check("mid_reach_500", {31'd0, to}, 32'd0);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("mid_rst_readdata", readdata, 32'd0);
      check("mid_rst_rd_en", {31'd0, res_rd_en}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_wc", 32'(word_count), 32'd0);
      check("mid_rst_addr", 32'(res_addr), 32'(BASE));
      read = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_stream(100, -1, 0, -1, n, de, se, we, ma, dl, to);
      check("restart_timeout", {31'd0, to}, 32'd0);
      check("restart_words", n, NUM);
      check("restart_data_errs", de, 0);
      check("restart_word0", captured[0], 32'h00010203);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
